// File: rtl/sdc_cmd_sequencer.sv
// SD command sequencer: captures index/arg, computes CRC7 serially, then paces the
// 48-bit command shift register with load/shift pulses, an idle gap and a done pulse.
module sdc_cmd_sequencer #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned GAP_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  output logic [47:0] full_cmd,
  output logic        load_cmd,
  output logic        shift_cmd,
  output logic        cmd_oe,
  output logic        busy,
  output logic        done
);

  localparam int unsigned IDX_W   = 6;
  localparam int unsigned ARG_W   = 32;
  localparam int unsigned CRC_W   = 7;
  localparam int unsigned MSG_W   = 2 + IDX_W + ARG_W;
  localparam int unsigned FRAME_W = MSG_W + CRC_W + 1;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GAP_CYC = GAP_BITS * CLK_DIV;
  localparam int unsigned GAP_W   = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CRC,
    S_LOAD,
    S_SHIFT,
    S_GAP,
    S_DONE
  } state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic [ARG_W-1:0]   arg_q, arg_n;
  logic [MSG_W-1:0]   msg_q, msg_n;
  logic [CRC_W-1:0]   crc_q, crc_n, crc_step;
  logic [CNT_W-1:0]   crc_cnt_q, crc_cnt_n;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_n;
  logic [DIV_W-1:0]   div_q, div_n;
  logic [GAP_W-1:0]   gap_q, gap_n;
  logic [FRAME_W-1:0] full_cmd_n;
  logic               fb;
  logic               cmd_ready_n, load_cmd_n, shift_cmd_n, cmd_oe_n, busy_n, done_n;

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      idx_q     <= '0;
      arg_q     <= '0;
      msg_q     <= '0;
      crc_q     <= '0;
      crc_cnt_q <= '0;
      bit_cnt_q <= '0;
      div_q     <= '0;
      gap_q     <= '0;
      full_cmd  <= '1;
      cmd_ready <= 1'b1;
      load_cmd  <= 1'b0;
      shift_cmd <= 1'b0;
      cmd_oe    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      idx_q     <= idx_n;
      arg_q     <= arg_n;
      msg_q     <= msg_n;
      crc_q     <= crc_n;
      crc_cnt_q <= crc_cnt_n;
      bit_cnt_q <= bit_cnt_n;
      div_q     <= div_n;
      gap_q     <= gap_n;
      full_cmd  <= full_cmd_n;
      cmd_ready <= cmd_ready_n;
      load_cmd  <= load_cmd_n;
      shift_cmd <= shift_cmd_n;
      cmd_oe    <= cmd_oe_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  // Next state, counters and next-cycle output values
  always_comb begin
    state_n    = state;
    idx_n      = idx_q;
    arg_n      = arg_q;
    msg_n      = msg_q;
    crc_n      = crc_q;
    crc_cnt_n  = crc_cnt_q;
    bit_cnt_n  = bit_cnt_q;
    div_n      = div_q;
    gap_n      = gap_q;
    full_cmd_n = full_cmd;
    fb         = msg_q[MSG_W-1] ^ crc_q[CRC_W-1];
    crc_step   = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);

    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          idx_n     = cmd_index;
          arg_n     = cmd_arg;
          msg_n     = {2'b01, cmd_index, cmd_arg};
          crc_n     = '0;
          crc_cnt_n = '0;
          state_n   = S_CRC;
        end
      end
      S_CRC: begin
        crc_n     = crc_step;
        msg_n     = {msg_q[MSG_W-2:0], 1'b0};
        crc_cnt_n = crc_cnt_q + CNT_W'(1);
        if (crc_cnt_q == CNT_W'(MSG_W - 1)) begin
          full_cmd_n = {2'b01, idx_q, arg_q, crc_step, 1'b1};
          crc_cnt_n  = '0;
          state_n    = S_LOAD;
        end
      end
      S_LOAD: begin
        div_n     = '0;
        bit_cnt_n = '0;
        state_n   = S_SHIFT;
      end
      S_SHIFT: begin
        div_n = div_q + DIV_W'(1);
        // Bit boundary: the shift pulse lands on the last cycle of each bit period
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_n     = '0;
          bit_cnt_n = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(FRAME_W - 1)) begin
            bit_cnt_n = '0;
            gap_n     = '0;
            state_n   = S_GAP;
          end
        end
      end
      S_GAP: begin
        gap_n = gap_q + GAP_W'(1);
        if (gap_q == GAP_W'(GAP_CYC - 1)) begin
          gap_n   = '0;
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    cmd_ready_n = (state_n == S_IDLE);
    busy_n      = (state_n != S_IDLE);
    load_cmd_n  = (state_n == S_LOAD);
    cmd_oe_n    = (state_n == S_SHIFT);
    shift_cmd_n = (state_n == S_SHIFT) && (div_n == DIV_W'(CLK_DIV - 1));
    done_n      = (state_n == S_DONE);
  end

endmodule

// File: tb/tb_sdc_cmd_sequencer.sv
// Bench for sdc_cmd_sequencer: default instance plus a CLK_DIV=2/GAP_BITS=1 instance,
// scoreboarded frames, per-cycle control timing and a modelled serial line.
module tb_sdc_cmd_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst;
  logic [1:0]       vld;
  logic [1:0]       rdy;
  logic [1:0][5:0]  idx;
  logic [1:0][31:0] arg;
  logic [1:0][47:0] fcmd;
  logic [1:0]       ld, sh, oe, bsy, dn;

  sdc_cmd_sequencer #(.CLK_DIV(4), .GAP_BITS(8)) u_dut0 (
    .clk(clk), .reset(rst[0]), .cmd_valid(vld[0]), .cmd_ready(rdy[0]),
    .cmd_index(idx[0]), .cmd_arg(arg[0]), .full_cmd(fcmd[0]), .load_cmd(ld[0]),
    .shift_cmd(sh[0]), .cmd_oe(oe[0]), .busy(bsy[0]), .done(dn[0])
  );

  sdc_cmd_sequencer #(.CLK_DIV(2), .GAP_BITS(1)) u_dut1 (
    .clk(clk), .reset(rst[1]), .cmd_valid(vld[1]), .cmd_ready(rdy[1]),
    .cmd_index(idx[1]), .cmd_arg(arg[1]), .full_cmd(fcmd[1]), .load_cmd(ld[1]),
    .shift_cmd(sh[1]), .cmd_oe(oe[1]), .busy(bsy[1]), .done(dn[1])
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference frame: {0,1,index,arg,crc7,1}, CRC7 poly x^7+x^3+1 over the first 40 bits
  function automatic logic [47:0] frame_of(input logic [5:0] i, input logic [31:0] a);
    logic [39:0] m;
    logic [6:0]  c;
    logic        f;
    m = {2'b01, i, a};
    c = '0;
    for (int k = 39; k >= 0; k--) begin
      f = m[k] ^ c[6];
      c = {c[5:0], 1'b0} ^ (f ? 7'h09 : 7'h00);
    end
    return {m, c, 1'b1};
  endfunction

  logic [47:0] q0[$];
  logic [47:0] q1[$];

  task automatic q_push(input int g, input logic [47:0] f);
    if (g == 0) q0.push_back(f); else q1.push_back(f);
  endtask

  function automatic logic [47:0] q_front(input int g);
    if (g == 0) return (q0.size() > 0) ? q0[0] : 48'hx;
    return (q1.size() > 0) ? q1[0] : 48'hx;
  endfunction

  task automatic q_pop(input int g);
    if (g == 0) begin
      if (q0.size() > 0) void'(q0.pop_front());
    end else begin
      if (q1.size() > 0) void'(q1.pop_front());
    end
  endtask

  task automatic q_clear(input int g);
    if (g == 0) q0.delete(); else q1.delete();
  endtask

  // Per-instance monitor state
  bit          act  [2];
  int          t0   [2];
  logic [47:0] sr   [2];
  logic [47:0] bits [2];
  int          nsh  [2];
  bit          rstd [2];

  task automatic mon(input int g);
    int d, gp, rel, done_rel;
    bit was;
    logic line;
    logic [5:0] obs, exp;
    d  = (g == 0) ? 4 : 2;
    gp = (g == 0) ? 8 : 1;
    if (rst[g]) begin
      act[g]  = 1'b0;
      sr[g]   = '1;
      nsh[g]  = 0;
      rstd[g] = 1'b1;
      q_clear(g);
      return;
    end
    was      = act[g];
    rel      = cyc - t0[g];
    done_rel = 42 + 48 * d + gp * d;
    exp[5] = !was;
    exp[4] = was;
    exp[3] = was && (rel == 41);
    exp[1] = was && (rel >= 42) && (rel <= 41 + 48 * d);
    exp[2] = exp[1] && (((rel - 41) % d) == 0);
    exp[0] = was && (rel == done_rel);
    obs = {rdy[g], bsy[g], ld[g], sh[g], oe[g], dn[g]};
    check_eq($sformatf("ctl%0d rel=%0d rdy/bsy/ld/sh/oe/dn", g, rel), 64'(obs), 64'(exp));
    if (rstd[g]) begin
      check_eq($sformatf("full_cmd_reset%0d", g), 64'(fcmd[g]), 64'hFFFF_FFFF_FFFF);
      rstd[g] = 1'b0;
    end
    line = oe[g] ? sr[g][47] : 1'b1;
    if (ld[g]) check_eq($sformatf("full_cmd%0d", g), 64'(fcmd[g]), 64'(q_front(g)));
    if (sh[g]) begin
      bits[g] = {bits[g][46:0], line};
      nsh[g]++;
      if (nsh[g] == 48) check_eq($sformatf("serial%0d", g), 64'(bits[g]), 64'(q_front(g)));
    end
    if (ld[g]) sr[g] = fcmd[g];
    else if (sh[g]) sr[g] = {sr[g][46:0], 1'b1};
    if (dn[g] && was) begin
      check_eq($sformatf("nshift%0d", g), 64'(nsh[g]), 64'd48);
      q_pop(g);
      act[g] = 1'b0;
    end
    if (!was && rdy[g] && vld[g]) begin
      act[g] = 1'b1;
      t0[g]  = cyc;
      nsh[g] = 0;
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic send(input int g, input logic [5:0] i, input logic [31:0] a,
                      input logic [47:0] f);
    @(posedge clk); #1;
    vld[g] = 1'b1;
    idx[g] = i;
    arg[g] = a;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (rdy[g]) begin
        q_push(g, f);
        @(posedge clk); #1;
        vld[g] = 1'b0;
        return;
      end
    end
    check_eq("accept_timeout", 64'd0, 64'd1);
    vld[g] = 1'b0;
  endtask

  task automatic wait_done(input int g);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (dn[g]) return;
    end
    check_eq("done_timeout", 64'd0, 64'd1);
  endtask

  // valid held high with inputs churning every cycle; expect exactly two accepts
  task automatic hold(input int g);
    int n;
    n = 0;
    @(posedge clk); #1;
    vld[g] = 1'b1;
    idx[g] = 6'd8;
    arg[g] = 32'h0000_01AA;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (rdy[g]) begin
        q_push(g, frame_of(idx[g], arg[g]));
        n++;
        if (n == 2) break;
      end
      @(posedge clk); #1;
      idx[g] = 6'($urandom);
      arg[g] = $urandom;
    end
    @(posedge clk); #1;
    vld[g] = 1'b0;
    if (n != 2) check_eq("hold_accepts", 64'(n), 64'd2);
  endtask

  initial begin
    rst = 2'b11;
    vld = '0;
    idx = '0;
    arg = '0;
    for (int g = 0; g < 2; g++) begin
      act[g] = 1'b0; t0[g] = 0; sr[g] = '1; bits[g] = '0; nsh[g] = 0; rstd[g] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 2'b00;

    send(0, 6'd0,  32'h0000_0000, 48'h40_0000_0000_95); wait_done(0);
    send(0, 6'd8,  32'h0000_01AA, 48'h48_0000_01AA_87); wait_done(0);
    send(0, 6'd17, 32'h0000_0000, 48'h51_0000_0000_55); wait_done(0);
    hold(0); wait_done(0);

    // Abort in the middle of bit 20, then a clean command
    send(0, 6'd17, 32'h1234_5678, frame_of(6'd17, 32'h1234_5678));
    repeat (41 + 20 * 4 + 2) @(posedge clk);
    #1 rst[0] = 1'b1;
    @(posedge clk); #1 rst[0] = 1'b0;
    repeat (3) @(posedge clk);
    send(0, 6'd55, 32'h0000_0000, frame_of(6'd55, 32'h0000_0000)); wait_done(0);

    send(1, 6'd8,  32'h0000_01AA, 48'h48_0000_01AA_87); wait_done(1);
    send(1, 6'd41, 32'h40FF_8000, frame_of(6'd41, 32'h40FF_8000)); wait_done(1);

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
